// File: rtl/lsu_pkg_rv32i.sv
// Shared encodings, widths and the access-size helper for the RV32I load/store unit.
package lsu_pkg_rv32i;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned LT_W   = 3;
  localparam int unsigned ST_W   = 2;

  typedef enum logic [LT_W-1:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b011,
    LT_LHU = 3'b100
  } loadtype_e;

  typedef enum logic [ST_W-1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } storetype_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC0 = 2'b01,
    S_ACC1 = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Access size in bytes; unused encodings fall back to a full word.
  function automatic logic [SIZE_W-1:0] access_size(
    input logic            is_store,
    input logic [LT_W-1:0] lt,
    input logic [ST_W-1:0] st
  );
    logic [SIZE_W-1:0] sz;
    sz = SIZE_W'(4);
    if (is_store) begin
      case (st)
        ST_SB:   sz = SIZE_W'(1);
        ST_SH:   sz = SIZE_W'(2);
        default: sz = SIZE_W'(4);
      endcase
    end else begin
      case (lt)
        LT_LB, LT_LBU: sz = SIZE_W'(1);
        LT_LH, LT_LHU: sz = SIZE_W'(2);
        default:       sz = SIZE_W'(4);
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_lane_rv32i.sv
// Combinational lane logic: byte-enable mask, write-data shift and load extraction/extension.
module lsu_lane_rv32i
  import lsu_pkg_rv32i::*;
(
  input  logic [OFF_W-1:0]    i_off,
  input  logic [SIZE_W-1:0]   i_size,
  input  logic [LT_W-1:0]     i_loadtype,
  input  logic [XLEN-1:0]     i_rs2,
  input  logic [XLEN-1:0]     i_lo,
  input  logic [XLEN-1:0]     i_hi,
  output logic [2*BE_W-1:0]   o_mask,
  output logic [2*XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]     o_load
);

  logic [2*BE_W-1:0] w_base;
  logic [4:0]        w_sh;
  logic [XLEN-1:0]   w_raw;

  always_comb begin
    w_base = 8'h0F;
    case (i_size)
      SIZE_W'(1): w_base = 8'h01;
      SIZE_W'(2): w_base = 8'h03;
      default:    w_base = 8'h0F;
    endcase
  end

  assign w_sh    = {i_off, 3'b000};
  assign o_mask  = w_base << i_off;
  assign o_wdata = {32'h0, i_rs2} << w_sh;
  assign w_raw   = XLEN'({i_hi, i_lo} >> w_sh);

  // Bytes beyond the access size are dropped here, so disabled lanes never leak in.
  always_comb begin
    o_load = w_raw;
    case (i_loadtype)
      LT_LB:   o_load = {{24{w_raw[7]}}, w_raw[7:0]};
      LT_LH:   o_load = {{16{w_raw[15]}}, w_raw[15:0]};
      LT_LBU:  o_load = {24'h0, w_raw[7:0]};
      LT_LHU:  o_load = {16'h0, w_raw[15:0]};
      default: o_load = w_raw;
    endcase
  end

endmodule

// File: rtl/lsu_bus_rv32i.sv
// Load/store unit: turns one core request into one or two aligned handshaked bus beats,
// stalling the core until the access completes.
module lsu_bus_rv32i
  import lsu_pkg_rv32i::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cu_load,
  input  logic             cu_store,
  input  logic [LT_W-1:0]  cu_loadtype,
  input  logic [ST_W-1:0]  cu_storetype,
  input  logic [XLEN-1:0]  dmem_addr,
  input  logic [XLEN-1:0]  rs2,
  output logic [XLEN-1:0]  load_out,
  output logic             stall,
  output logic             lsu_misalign,
  output logic             bus_req,
  output logic             bus_we,
  output logic [XLEN-1:0]  bus_addr,
  output logic [BE_W-1:0]  bus_be,
  output logic [XLEN-1:0]  bus_wdata,
  input  logic             bus_ack,
  input  logic [XLEN-1:0]  bus_rdata
);

  state_e            r_state,     w_state_nxt;
  logic [OFF_W-1:0]  r_off,       w_off_nxt;
  logic [XLEN-1:0]   r_rs2,       w_rs2_nxt;
  logic [LT_W-1:0]   r_lt,        w_lt_nxt;
  logic [ST_W-1:0]   r_st,        w_st_nxt;
  logic [XLEN-1:0]   r_lo,        w_lo_nxt;
  logic [XLEN-1:0]   r_load_out,  w_load_out_nxt;
  logic              r_misalign,  w_misalign_nxt;
  logic              r_bus_req,   w_bus_req_nxt;
  logic              r_bus_we,    w_bus_we_nxt;
  logic [XLEN-1:0]   r_bus_addr,  w_bus_addr_nxt;
  logic [BE_W-1:0]   r_bus_be,    w_bus_be_nxt;
  logic [XLEN-1:0]   r_bus_wdata, w_bus_wdata_nxt;

  logic              w_idle;
  logic              w_req;
  logic              w_sel_store;
  logic [OFF_W-1:0]  w_off;
  logic [XLEN-1:0]   w_sel_data;
  logic [LT_W-1:0]   w_sel_lt;
  logic [ST_W-1:0]   w_sel_st;
  logic [SIZE_W-1:0] w_size;
  logic              w_split;
  logic              w_misal;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN-1:0]   w_hi;
  logic [2*BE_W-1:0] w_mask;
  logic [2*XLEN-1:0] w_wdata64;
  logic [XLEN-1:0]   w_load;

  // In IDLE the lane logic sees the live request; afterwards it sees the captured one.
  assign w_idle      = (r_state == S_IDLE);
  assign w_req       = cu_load | cu_store;
  assign w_sel_store = w_idle ? cu_store     : r_bus_we;
  assign w_off       = w_idle ? dmem_addr[1:0] : r_off;
  assign w_sel_data  = w_idle ? rs2          : r_rs2;
  assign w_sel_lt    = w_idle ? cu_loadtype  : r_lt;
  assign w_sel_st    = w_idle ? cu_storetype : r_st;
  assign w_size      = access_size(w_sel_store, w_sel_lt, w_sel_st);
  assign w_split     = (SIZE_W'(w_off) + w_size) > SIZE_W'(4);
  assign w_misal     = (w_off & OFF_W'(w_size - SIZE_W'(1))) != '0;
  assign w_lo        = (r_state == S_ACC1) ? r_lo : bus_rdata;
  assign w_hi        = (r_state == S_ACC1) ? bus_rdata : '0;

  lsu_lane_rv32i u_lane (
    .i_off      (w_off),
    .i_size     (w_size),
    .i_loadtype (w_sel_lt),
    .i_rs2      (w_sel_data),
    .i_lo       (w_lo),
    .i_hi       (w_hi),
    .o_mask     (w_mask),
    .o_wdata    (w_wdata64),
    .o_load     (w_load)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_off_nxt       = r_off;
    w_rs2_nxt       = r_rs2;
    w_lt_nxt        = r_lt;
    w_st_nxt        = r_st;
    w_lo_nxt        = r_lo;
    w_load_out_nxt  = r_load_out;
    w_misalign_nxt  = r_misalign;
    w_bus_req_nxt   = r_bus_req;
    w_bus_we_nxt    = r_bus_we;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_be_nxt    = r_bus_be;
    w_bus_wdata_nxt = r_bus_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_off_nxt = dmem_addr[1:0];
          w_rs2_nxt = rs2;
          w_lt_nxt  = cu_loadtype;
          w_st_nxt  = cu_storetype;
          if (!SPLIT_EN && w_misal) begin
            w_state_nxt    = S_DONE;
            w_misalign_nxt = 1'b1;
            w_load_out_nxt = '0;
          end else begin
            w_state_nxt     = S_ACC0;
            w_bus_req_nxt   = 1'b1;
            w_bus_we_nxt    = cu_store;
            w_bus_addr_nxt  = {dmem_addr[XLEN-1:2], 2'b00};
            w_bus_be_nxt    = w_mask[BE_W-1:0];
            w_bus_wdata_nxt = w_wdata64[XLEN-1:0];
          end
        end
      end
      S_ACC0: begin
        if (bus_ack) begin
          w_lo_nxt = bus_rdata;
          if (w_split) begin
            w_state_nxt     = S_ACC1;
            w_bus_addr_nxt  = r_bus_addr + XLEN'(4);
            w_bus_be_nxt    = w_mask[2*BE_W-1:BE_W];
            w_bus_wdata_nxt = w_wdata64[2*XLEN-1:XLEN];
          end else begin
            w_state_nxt    = S_DONE;
            w_bus_req_nxt  = 1'b0;
            w_load_out_nxt = r_bus_we ? '0 : w_load;
          end
        end
      end
      S_ACC1: begin
        if (bus_ack) begin
          w_state_nxt    = S_DONE;
          w_bus_req_nxt  = 1'b0;
          w_load_out_nxt = r_bus_we ? '0 : w_load;
        end
      end
      S_DONE: begin
        w_state_nxt    = S_IDLE;
        w_misalign_nxt = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_rs2       <= '0;
      r_lt        <= '0;
      r_st        <= '0;
      r_lo        <= '0;
      r_load_out  <= '0;
      r_misalign  <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_off       <= w_off_nxt;
      r_rs2       <= w_rs2_nxt;
      r_lt        <= w_lt_nxt;
      r_st        <= w_st_nxt;
      r_lo        <= w_lo_nxt;
      r_load_out  <= w_load_out_nxt;
      r_misalign  <= w_misalign_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_be    <= w_bus_be_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
    end
  end

  // Stall is the only combinational output: the core must freeze in the request cycle itself.
  assign stall = !rst && ((w_idle && w_req) || (r_state == S_ACC0) || (r_state == S_ACC1));

  assign load_out     = r_load_out;
  assign lsu_misalign = r_misalign;
  assign bus_req      = r_bus_req;
  assign bus_we       = r_bus_we;
  assign bus_addr     = r_bus_addr;
  assign bus_be       = r_bus_be;
  assign bus_wdata    = r_bus_wdata;

endmodule

// File: doc/lsu_bus_rv32i.md
# lsu_bus_rv32i

Load/store unit between the core's memory-access stage and a handshaked data-memory bus; it replaces the single-cycle data-memory path. It turns one `cu_store`/`cu_load` request into one or two word-aligned bus transactions, with byte enables, lane shifting and load extension. It holds the core with `stall` until the access completes. Misaligned halfword and word accesses are split into two aligned beats, or flagged when splitting is disabled.

## Interface
- `SPLIT_EN`, 1: 1 = split misaligned accesses into two beats; 0 = flag them on `lsu_misalign`, with no bus traffic.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cu_load` in 1: load request; held stable by the core while `stall`=1.
- `cu_store` in 1: store request; takes priority if asserted together with `cu_load`.
- `cu_loadtype` in 3: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU.
- `cu_storetype` in 2: 00 SB, 01 SH, 10 SW.
- `dmem_addr` in 32: byte address from the ALU.
- `rs2` in 32: store data.
- `load_out` out 32: extended load result; valid in DONE.
- `stall` out 1: freeze PC and register-file write.
- `lsu_misalign` out 1: one-cycle pulse in DONE when `SPLIT_EN`=0 and the access is misaligned.
- `bus_req` out 1: transaction request; held until `bus_ack`.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word-aligned address; bits [1:0] are always 00.
- `bus_be` out 4: byte enables; bit i selects byte lane i.
- `bus_wdata` out 32: lane-aligned write data.
- `bus_ack` in 1: completes the current beat when `bus_req`=1.
- `bus_rdata` in 32: read data; valid in the `bus_ack` cycle.

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- IDLE, on `cu_load`|`cu_store`:
  - Register the address, `rs2`, the type and direction.
  - Compute beat 0 and set `bus_req`=1.
  - Go to ACC0.
  - If `SPLIT_EN`=0 and the access is misaligned, go directly to DONE with `lsu_misalign` set.
- `stall` = (IDLE & request) | ACC0 | ACC1. It is combinational and is 0 in DONE.
- ACC0, on `bus_ack`:
  - Capture `bus_rdata` as lo.
  - If the access is split, load beat 1 and go to ACC1 with `bus_req` still 1.
  - Otherwise drop `bus_req` and go to DONE.
- ACC1, on `bus_ack`: capture hi, drop `bus_req`, go to DONE.
- DONE:
  - `load_out` is valid.
  - Always returns to IDLE next cycle.
  - Ignores the still-asserted request of the finishing instruction.
- Offset `off` = `dmem_addr[1:0]`. Access size is 1, 2 or 4 bytes.
- The access is split when off + size > 4. Possible cases: SH with off=3; SW with off≠0.
- Byte shift `sh` = 8*off.
- Beat 0:
  - `bus_addr` = {addr[31:2],00}.
  - `bus_be` = the low 4 bits of the 8-bit mask (size ones) << off.
  - `bus_wdata` = low word of the 64-bit value {32'b0,rs2} << `sh`.
- Beat 1:
  - `bus_addr` = beat-0 address + 4, wrapping at 2^32 (0xFFFFFFFC → 0x00000000).
  - `bus_be` and `bus_wdata` are the high halves of the same mask and data.
- Load:
  - raw = ({hi,lo} >> `sh`)[31:0], with hi=0 when the access is not split.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Bytes outside the enabled lanes are ignored.
- `bus_we` = store; it is constant for both beats.
- `load_out` = 0 for stores and for flagged misaligned accesses.

## Timing
- Reset values:
  - state IDLE
  - `bus_req`, `bus_we` = 0
  - `bus_addr`, `bus_be`, `bus_wdata` = 0
  - `load_out` = 0
  - `lsu_misalign` = 0
  - `stall` = 0 while `rst`=1
- Bus outputs are registered.
- Bus handshake:
  - `bus_req` rises the cycle after the request is seen in IDLE.
  - Address, enables, data and direction are stable while `bus_req`=1 and `bus_ack`=0.
  - A beat completes on the edge where `bus_req`&`bus_ack`=1.
- Aligned access with zero-wait ack (cycle 0 = request in IDLE):
  - Cycles 0–1: `stall`=1.
  - Cycle 2: DONE, and the core commits at the end of this cycle.
- Split access adds exactly one cycle plus any ack wait.
- Each ack wait cycle extends ACC0 or ACC1 by one cycle.
- Reset asserted mid-transaction: all registers return to their reset values at the next edge and the transaction is abandoned. The bus must tolerate the dropped `bus_req`.
- `bus_ack` while `bus_req`=0 is ignored.

## Structure
- Package `lsu_pkg_rv32i` holds:
  - the loadtype and storetype encodings
  - the state enum
  - size constants
- Sub-module `lsu_lane_rv32i` (combinational) computes the byte-enable mask, the 64-bit write shift, and load extraction/extension. The FSM and registers stay in the top.

## Test plan
- SW `rs2`=0xDEADBEEF to 0x100, ack same cycle → single beat:
  - addr 0x100, be 1111, wdata 0xDEADBEEF
  - `stall` high exactly 2 cycles
- SB `rs2`=0x000000A5 to 0x102 → single beat: be 0100, wdata 0x00A50000.
- LH at 0x203 with SPLIT_EN=1:
  - beat 0: addr 0x200, be 1000, rdata 0x80xxxxxx
  - beat 1: addr 0x204, be 0001, rdata 0xxxxxxxFF
  - result: `load_out`=0xFFFFFF80
- LB and LBU at 0x301 with rdata 0x0000F000 → `load_out` 0xFFFFFFF0 and 0x000000F0 respectively.
- LW at 0x400 with ack delayed 3 cycles → `bus_req` and `bus_addr` stable for 4 cycles; `stall` high 5 cycles.
- Reset and misalignment cases:
  - `rst` asserted in ACC1 of an SW to 0xFFFFFFFE → next cycle: IDLE, `bus_req`=0, all outputs 0.
  - With SPLIT_EN=0, SW to 0x01 → `lsu_misalign` pulses once, no `bus_req`, `stall` high 1 cycle.
